// File: rtl/adc_acq_pkg.sv
// Shared ADC acquisition types and constants.
// Used by the divider stage and the frame packer.
package adc_acq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    DONE
  } acq_state_t;

  localparam int PACK_W = 16;
  localparam int WORD_W = 32;
  localparam int DEFAULT_NUMBER_SAMPLES = 1024;

endpackage

// File: rtl/adc_half_packer.sv
// Pairs consecutive 16-bit samples into one 32-bit FIFO word.
// The earlier sample of each pair lands in the low half.
module adc_half_packer
  import adc_acq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              strobe,
  input  logic              full,
  input  logic [PACK_W-1:0] data,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic              drop
);

  logic              phase;
  logic [PACK_W-1:0] lo;

  // A completed pair with the FIFO full is lost.
  assign drop = strobe & phase & full;

  // Hold the low half, then emit the word one cycle after the pair closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= 1'b0;
      lo      <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        phase <= 1'b0;
      end else if (strobe) begin
        if (!phase) begin
          lo    <= data;
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (!full) begin
            wr_en   <= 1'b1;
            wr_data <= {data, lo};
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Frames NUMBER_SAMPLES ADC samples per Start into packed FIFO words.
// Signals completion, aborts and FIFO overflow to the DMA side.
module adc_frame_packer
  import adc_acq_pkg::*;
#(
  parameter int NUMBER_SAMPLES = DEFAULT_NUMBER_SAMPLES,
  parameter int ADC_WIDTH      = 12,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [ADC_WIDTH-1:0] ADC_Data,
  input  logic                 Acq_Valid,
  input  logic                 FIFO_Full,
  output logic                 FIFO_Wr_En,
  output logic [WORD_W-1:0]    FIFO_Wr_Data,
  output logic                 Busy,
  output logic                 Frame_Done,
  output logic                 Overflow,
  output logic [CNT_WIDTH-1:0] Sample_Cnt
);

  if ((NUMBER_SAMPLES < 2) || ((NUMBER_SAMPLES % 2) != 0)) begin : g_bad_n
    $error("NUMBER_SAMPLES must be even and >= 2");
  end
  if (ADC_WIDTH > PACK_W) begin : g_bad_w
    $error("ADC_WIDTH must be <= 16");
  end
  if ((1 << CNT_WIDTH) <= NUMBER_SAMPLES) begin : g_bad_c
    $error("CNT_WIDTH too small for NUMBER_SAMPLES");
  end

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(NUMBER_SAMPLES - 1);

  acq_state_t        state;
  logic [PACK_W-1:0] sample;
  logic              accept;
  logic              clear;
  logic              drop;

  assign sample = PACK_W'(ADC_Data);
  assign accept = (state == ACQ) & Acq_Valid & ~Abort;
  assign clear  = Abort | (state != ACQ);

  adc_half_packer u_half (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (clear),
    .strobe  (accept),
    .full    (FIFO_Full),
    .data    (sample),
    .wr_en   (FIFO_Wr_En),
    .wr_data (FIFO_Wr_Data),
    .drop    (drop)
  );

  // Frame sequencing; Abort outranks Start, samples and completion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
      Overflow   <= 1'b0;
      Sample_Cnt <= '0;
    end else begin
      Frame_Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start && !Abort) begin
            state      <= ACQ;
            Busy       <= 1'b1;
            Sample_Cnt <= '0;
            Overflow   <= 1'b0;
          end
        end
        ACQ: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (Acq_Valid) begin
            Sample_Cnt <= Sample_Cnt + CNT_WIDTH'(1);
            if (drop) Overflow <= 1'b1;
            if (Sample_Cnt == LAST) begin
              state      <= DONE;
              Busy       <= 1'b0;
              Frame_Done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Randomised self-checking bench for adc_frame_packer.
// Reference model works on sample index parity and queues.
module tb_adc_frame_packer;
  import adc_acq_pkg::*;

  localparam int N  = DEFAULT_NUMBER_SAMPLES;
  localparam int AW = 12;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] adc_data = '0;
  logic          acq_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [CW-1:0] sample_cnt;

  adc_frame_packer #(
    .NUMBER_SAMPLES (N),
    .ADC_WIDTH      (AW),
    .CNT_WIDTH      (CW)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .Start        (start),
    .Abort        (abort),
    .ADC_Data     (adc_data),
    .Acq_Valid    (acq_valid),
    .FIFO_Full    (fifo_full),
    .FIFO_Wr_En   (wr_en),
    .FIFO_Wr_Data (wr_data),
    .Busy         (busy),
    .Frame_Done   (frame_done),
    .Overflow     (overflow),
    .Sample_Cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int          got_wc[$];
  logic [31:0] got_wd[$];
  int          got_done[$];
  int          exp_wc[$];
  logic [31:0] exp_wd[$];
  int          exp_done[$];

  // model: 0 idle, 1 acquiring, 2 done cycle
  int          m_mode = 0;
  int          m_cnt = 0;
  bit          m_ovf = 0;
  logic [15:0] m_lo = '0;
  bit          m_known = 0;
  int          busy_bad = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_wc.push_back(cyc);
      got_wd.push_back(wr_data);
    end
    if (frame_done === 1'b1) got_done.push_back(cyc);
  end

  task automatic clear_logs();
    got_wc.delete();
    got_wd.delete();
    got_done.delete();
    exp_wc.delete();
    exp_wd.delete();
    exp_done.delete();
    busy_bad = 0;
  endtask

  function automatic int wr_diffs();
    int n = 0;
    int m;
    if (got_wc.size() != exp_wc.size()) n++;
    m = (got_wc.size() < exp_wc.size()) ?
        got_wc.size() : exp_wc.size();
    for (int i = 0; i < m; i++)
      if (got_wc[i] != exp_wc[i] || got_wd[i] !== exp_wd[i]) n++;
    return n;
  endfunction

  function automatic int done_diffs();
    int n = 0;
    if (got_done.size() != exp_done.size()) return 1;
    for (int i = 0; i < got_done.size(); i++)
      if (got_done[i] != exp_done[i]) n++;
    return n;
  endfunction

  // One clock of stimulus; the model advances by the same rules.
  task automatic drive(input bit r, input bit s, input bit a,
                       input bit v, input logic [AW-1:0] d,
                       input bit f);
    bit          busy_exp;
    int          c;
    logic [15:0] ext;
    @(posedge clk);
    #1;
    rst = r; start = s; abort = a;
    acq_valid = v; adc_data = d; fifo_full = f;
    c = cyc;
    ext = {4'h0, d};
    busy_exp = (m_mode == 1);
    if (r) begin
      m_mode = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_mode == 0) begin
      if (s && !a) begin
        m_mode = 1; m_cnt = 0; m_ovf = 0;
      end
    end else if (m_mode == 1) begin
      if (a) m_mode = 0;
      else if (v) begin
        if (m_cnt % 2 == 0) m_lo = ext;
        else if (f) m_ovf = 1;
        else begin
          exp_wc.push_back(c + 1);
          exp_wd.push_back({ext, m_lo});
        end
        m_cnt++;
        if (m_cnt == N) begin
          m_mode = 2;
          exp_done.push_back(c + 1);
        end
      end
    end else begin
      m_mode = 0;
    end
    @(negedge clk);
    if (m_known && busy !== busy_exp) busy_bad++;
    if (r) m_known = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, AW'($urandom), 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      drive(1, 1, 0, 1, AW'($urandom), 0);
    checks++;
    if (wr_en !== 1'b0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_fifo: en=%b data=%h want 0", wr_en, wr_data);
    end
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fsm: busy=%b done=%b want 0", busy, frame_done);
    end
    checks++;
    if (sample_cnt !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: cnt=%0d ovf=%b want 0", sample_cnt, overflow);
    end
    idle(2);
  endtask

  task automatic test_full_frame();
    clear_logs();
    drive(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, 2));
      drive(0, 0, 0, 1, AW'(i), 0);
    end
    idle(3);
    checks++;
    if (got_wc.size() != 512) begin
      errors++;
      $display("FAIL frame_writes: got %0d want 512", got_wc.size());
    end
    checks++;
    if (got_wd.size() == 0 || got_wd[0] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL frame_first: got %h want 00010000",
               got_wd.size() ? got_wd[0] : 32'hx);
    end
    checks++;
    if (got_wd.size() == 0 || got_wd[$] !== 32'h03FF_03FE) begin
      errors++;
      $display("FAIL frame_last: got %h want 03ff03fe",
               got_wd.size() ? got_wd[$] : 32'hx);
    end
    checks++;
    if (wr_diffs() != 0) begin
      errors++;
      $display("FAIL frame_stream: %0d diffs want 0", wr_diffs());
    end
    checks++;
    if (done_diffs() != 0) begin
      errors++;
      $display("FAIL frame_done: %0d pulses want 1", got_done.size());
    end
    checks++;
    if (sample_cnt !== CW'(N) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL frame_cnt: cnt=%0d ovf=%b want %0d 0",
               sample_cnt, overflow, N);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL frame_busy: %0d bad cycles want 0", busy_bad);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    drive(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < N; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    idle(3);
    checks++;
    if (wr_diffs() != 0 || got_wc.size() != N / 2) begin
      errors++;
      $display("FAIL b2b_stream: %0d writes %0d diffs want %0d 0",
               got_wc.size(), wr_diffs(), N / 2);
    end
    checks++;
    if (done_diffs() != 0 || sample_cnt !== CW'(N)) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d cnt=%0d want 1 %0d",
               got_done.size(), sample_cnt, N);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL b2b_busy: %0d bad cycles want 0", busy_bad);
    end
  endtask

  task automatic test_overflow();
    bit f;
    clear_logs();
    drive(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < N; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--)
        drive(0, 0, 0, 0, AW'($urandom), 1'($urandom));
      if (i == 5) f = 1;
      else if (i % 2 == 0) f = 1'($urandom);
      else f = 0;
      drive(0, 0, 0, 1, AW'($urandom), f);
    end
    idle(3);
    checks++;
    if (got_wc.size() != N / 2 - 1 || wr_diffs() != 0) begin
      errors++;
      $display("FAIL ovf_stream: %0d writes %0d diffs want %0d 0",
               got_wc.size(), wr_diffs(), N / 2 - 1);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    checks++;
    if (done_diffs() != 0) begin
      errors++;
      $display("FAIL ovf_done: %0d pulses want 1", got_done.size());
    end
  endtask

  task automatic test_abort();
    clear_logs();
    drive(0, 1, 0, 0, '0, 0);
    drive(0, 0, 0, 0, '0, 0);
    checks++;
    if (sample_cnt !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: cnt=%0d ovf=%b want 0 0",
               sample_cnt, overflow);
    end
    for (int i = 0; i < 7; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    drive(0, 1, 1, 1, AW'($urandom), 0);
    idle(3);
    checks++;
    if (got_wc.size() != 3 || wr_diffs() != 0) begin
      errors++;
      $display("FAIL abort_stream: %0d writes want 3", got_wc.size());
    end
    checks++;
    if (got_done.size() != 0 || sample_cnt !== CW'(7)) begin
      errors++;
      $display("FAIL abort_hold: pulses=%0d cnt=%0d want 0 7",
               got_done.size(), sample_cnt);
    end
    clear_logs();
    drive(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < N - 1; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    drive(0, 0, 1, 1, AW'($urandom), 0);
    idle(3);
    checks++;
    if (got_done.size() != 0 || sample_cnt !== CW'(N - 1)
        || wr_diffs() != 0) begin
      errors++;
      $display("FAIL abort_last: pulses=%0d cnt=%0d want 0 %0d",
               got_done.size(), sample_cnt, N - 1);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL abort_busy: %0d bad cycles want 0", busy_bad);
    end
  endtask

  task automatic test_start_edges();
    clear_logs();
    drive(0, 1, 0, 1, AW'($urandom), 0);
    drive(0, 0, 0, 0, '0, 0);
    checks++;
    if (sample_cnt !== '0) begin
      errors++;
      $display("FAIL start_valid: cnt=%0d want 0", sample_cnt);
    end
    for (int i = 0; i < 3; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    drive(0, 1, 0, 1, AW'($urandom), 0);
    for (int i = 0; i < 2; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    drive(0, 0, 0, 0, '0, 0);
    checks++;
    if (sample_cnt !== CW'(6) || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_acq: cnt=%0d busy=%b want 6 1",
               sample_cnt, busy);
    end
    drive(0, 0, 1, 0, '0, 0);
    drive(0, 1, 1, 0, '0, 0);
    idle(2);
    checks++;
    if (busy !== 1'b0 || sample_cnt !== CW'(6)) begin
      errors++;
      $display("FAIL start_abort: busy=%b cnt=%0d want 0 6",
               busy, sample_cnt);
    end
    checks++;
    if (wr_diffs() != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL edges_stream: %0d diffs %0d busy want 0 0",
               wr_diffs(), busy_bad);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    drive(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    drive(1, 0, 0, 1, AW'($urandom), 0);
    drive(0, 0, 0, 1, AW'($urandom), 0);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || sample_cnt !== '0
        || overflow !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: en=%b busy=%b cnt=%0d want 0 0 0",
               wr_en, busy, sample_cnt);
    end
    for (int i = 0; i < 6; i++)
      drive(0, 0, 0, 1, AW'($urandom), 0);
    idle(2);
    checks++;
    if (got_wc.size() != 2 || wr_diffs() != 0) begin
      errors++;
      $display("FAIL rst_no_write: %0d writes want 2", got_wc.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_start_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
